// File: rtl/hub75_pkg.sv
// Shared constants and types for the HUB75 scan path.
package hub75_pkg;

    // Address and plane-select widths as seen on the fetch and panel sides.
    localparam int COL_W      = 6;
    localparam int ROW_W      = 4;
    localparam int BITPLANE_W = 3;

    // Scan sequencer states.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH_START,
        ST_FETCH_ARM,
        ST_FETCH_WAIT,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_BLANK_PRE,
        ST_LATCH,
        ST_BLANK_POST,
        ST_DISPLAY
    } seq_state_e;

    // Width of a down-counter that must hold BASE_DISPLAY<<(BITPLANES-1).
    function automatic int unsigned display_cnt_width(input int unsigned bitplanes,
                                                      input int unsigned base_display);
        return bitplanes - 1 + $clog2(base_display) + 1;
    endfunction

endpackage

// File: rtl/hub75_scan_sequencer_if.sv
// Handshake between the scan sequencer and the framebuffer fetch block.
interface hub75_scan_sequencer_if;
    import hub75_pkg::*;

    logic [COL_W-1:0]      column_address;
    logic [ROW_W-1:0]      row_address;
    logic [BITPLANE_W-1:0] bitplane;
    logic                  pixel_load_start;
    logic                  fetch_busy;

    // Sequencer side: presents the pixel coordinate and start pulse.
    modport master (
        output column_address,
        output row_address,
        output bitplane,
        output pixel_load_start,
        input  fetch_busy
    );

    // Fetch block side: consumes the coordinate, reports busy.
    modport slave (
        input  column_address,
        input  row_address,
        input  bitplane,
        input  pixel_load_start,
        output fetch_busy
    );

endinterface

// File: rtl/hub75_scan_sequencer_bcm_display_timer.sv
// Bitplane-weighted display timer: on start, loads BASE_DISPLAY<<plane and
// counts down; done is high in the last cycle of the display window.
module bcm_display_timer
    import hub75_pkg::*;
#(
    parameter int BITPLANES    = 6,
    parameter int BASE_DISPLAY = 8
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [BITPLANE_W-1:0] plane_i,
    output logic                  done_o
);

    localparam int CNT_W = int'(display_cnt_width(BITPLANES, BASE_DISPLAY));

    logic [CNT_W-1:0] count_q, count_d;
    logic             run_q, run_d;

    // Load N-1 so that the window is N cycles counting the load-following cycle.
    always_comb begin
        count_d = count_q;
        run_d   = run_q;
        if (start_i) begin
            count_d = CNT_W'((BASE_DISPLAY << plane_i) - 1);
            run_d   = 1'b1;
        end else if (run_q) begin
            if (count_q == '0) begin
                run_d = 1'b0;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Counter state registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            count_q <= '0;
            run_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            run_q   <= run_d;
        end
    end

    assign done_o = run_q && (count_q == '0);

endmodule

// File: rtl/hub75_scan_sequencer.sv
// HUB75 scan scheduler: per bitplane and row, fetches and shifts every column,
// then blanks, latches and displays the row for a bitplane-weighted time.
module hub75_scan_sequencer
    import hub75_pkg::*;
#(
    parameter int COLUMNS      = 64,
    parameter int ROWS         = 16,
    parameter int BITPLANES    = 6,
    parameter int BASE_DISPLAY = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic                          enable,
    hub75_scan_sequencer_if.master        fetch,
    output logic                          panel_clk,
    output logic                          panel_latch,
    output logic                          panel_oe_n,
    output logic                          frame_done
);

    localparam logic [COL_W-1:0]      COL_LAST   = COL_W'(COLUMNS - 1);
    localparam logic [ROW_W-1:0]      ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [BITPLANE_W-1:0] PLANE_LAST = BITPLANE_W'(BITPLANES - 1);
    localparam int                    BLK_W      = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BLK_W-1:0]      BLK_LAST   = BLK_W'(BLANK_CYCLES - 1);

    seq_state_e            state_q;
    logic [COL_W-1:0]      col_q;
    logic [ROW_W-1:0]      row_q;
    logic [BITPLANE_W-1:0] plane_q;
    logic [BLK_W-1:0]      blank_q;
    logic                  start_q;
    logic                  pclk_q;
    logic                  latch_q;
    logic                  oe_n_q;
    logic                  frame_q;
    logic                  timer_start;
    logic                  timer_done;

    // Timer is loaded on the last blanking cycle so its window lines up exactly
    // with the cycles in which the registered OE is low.
    assign timer_start = (state_q == ST_BLANK_POST) && (blank_q == BLK_LAST);

    bcm_display_timer #(
        .BITPLANES    (BITPLANES),
        .BASE_DISPLAY (BASE_DISPLAY)
    ) u_timer (
        .clk_in  (clk_in),
        .reset   (reset),
        .start_i (timer_start),
        .plane_i (plane_q),
        .done_o  (timer_done)
    );

    // Scan FSM with registered outputs; outputs are set on the transition into
    // the state in which they must be visible.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            plane_q <= '0;
            blank_q <= '0;
            start_q <= 1'b0;
            pclk_q  <= 1'b0;
            latch_q <= 1'b0;
            oe_n_q  <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            frame_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q <= ST_FETCH_START;
                        start_q <= 1'b1;
                    end
                end
                ST_FETCH_START: begin
                    state_q <= ST_FETCH_ARM;
                end
                ST_FETCH_ARM: begin
                    state_q <= ST_FETCH_WAIT;
                end
                ST_FETCH_WAIT: begin
                    if (!fetch.fetch_busy) begin
                        state_q <= ST_SHIFT_HI;
                        pclk_q  <= 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    state_q <= ST_SHIFT_LO;
                    pclk_q  <= 1'b0;
                end
                ST_SHIFT_LO: begin
                    if (col_q == COL_LAST) begin
                        col_q   <= '0;
                        blank_q <= '0;
                        state_q <= ST_BLANK_PRE;
                    end else begin
                        col_q   <= col_q + 1'b1;
                        state_q <= ST_FETCH_START;
                        start_q <= 1'b1;
                    end
                end
                ST_BLANK_PRE: begin
                    if (blank_q == BLK_LAST) begin
                        state_q <= ST_LATCH;
                        latch_q <= 1'b1;
                    end else begin
                        blank_q <= blank_q + 1'b1;
                    end
                end
                ST_LATCH: begin
                    latch_q <= 1'b0;
                    blank_q <= '0;
                    state_q <= ST_BLANK_POST;
                end
                ST_BLANK_POST: begin
                    if (blank_q == BLK_LAST) begin
                        state_q <= ST_DISPLAY;
                        oe_n_q  <= 1'b0;
                    end else begin
                        blank_q <= blank_q + 1'b1;
                    end
                end
                ST_DISPLAY: begin
                    if (timer_done) begin
                        oe_n_q <= 1'b1;
                        if (plane_q != PLANE_LAST) begin
                            plane_q <= plane_q + 1'b1;
                            state_q <= ST_FETCH_START;
                            start_q <= 1'b1;
                        end else begin
                            plane_q <= '0;
                            if (row_q != ROW_LAST) begin
                                row_q   <= row_q + 1'b1;
                                state_q <= ST_FETCH_START;
                                start_q <= 1'b1;
                            end else begin
                                row_q   <= '0;
                                frame_q <= 1'b1;
                                if (enable) begin
                                    state_q <= ST_FETCH_START;
                                    start_q <= 1'b1;
                                end else begin
                                    state_q <= ST_IDLE;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign fetch.column_address   = col_q;
    assign fetch.row_address      = row_q;
    assign fetch.bitplane         = plane_q;
    assign fetch.pixel_load_start = start_q;
    assign panel_clk              = pclk_q;
    assign panel_latch            = latch_q;
    assign panel_oe_n             = oe_n_q;
    assign frame_done             = frame_q;

endmodule

// File: tb/tb_hub75_scan_sequencer.sv
// Scoreboard bench for hub75_scan_sequencer with a simple fetch_busy model.
module tb_hub75_scan_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic panel_clk, panel_latch, panel_oe_n, frame_done;

    hub75_scan_sequencer_if ifc();

    hub75_scan_sequencer #(
        .COLUMNS      (64),
        .ROWS         (16),
        .BITPLANES    (6),
        .BASE_DISPLAY (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk_in      (clk),
        .reset       (reset),
        .enable      (enable),
        .fetch       (ifc),
        .panel_clk   (panel_clk),
        .panel_latch (panel_latch),
        .panel_oe_n  (panel_oe_n),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Fetch model: busy for busy_len cycles after each start; a one-shot
    // 50-cycle stall at column 10 when stall_req is set.
    int unsigned busy_len = 4;
    logic        stall_req = 1'b0;
    int unsigned busy_cnt = 0;
    always @(posedge clk) begin
        if (reset) begin
            busy_cnt <= 0;
        end else if (ifc.pixel_load_start) begin
            if (stall_req && ifc.column_address == 6'd10) begin
                busy_cnt  <= 50;
                stall_req <= 1'b0;
            end else begin
                busy_cnt <= busy_len;
            end
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign ifc.fetch_busy = (busy_cnt != 0);

    // Scoreboard queues
    logic [31:0] exp_latch[$];
    logic [31:0] exp_oe[$];
    logic [31:0] exp_frame[$];
    logic        mon_en = 1'b0;

    int unsigned pulses = 0;
    int unsigned oe_len = 0;
    logic        prev_pclk = 1'b0, prev_latch = 1'b0, prev_oe = 1'b1;
    logic [3:0]  prev_row = '0, win_row = '0;
    logic [2:0]  win_plane = '0;

    // Monitor: observes outputs between edges and compares each event to the queue head.
    always @(negedge clk) begin
        if (mon_en) begin
            if (panel_clk && !prev_pclk) pulses++;
            if (panel_latch && !prev_latch) begin
                if (exp_latch.size() == 0) chk("latch_unexpected", 32'd1, 32'd0);
                else chk("latch_clk_pulses", pulses, exp_latch.pop_front());
                pulses = 0;
            end
            if (!panel_oe_n) begin
                oe_len++;
                win_row   = ifc.row_address;
                win_plane = ifc.bitplane;
            end else if (!prev_oe) begin
                if (exp_oe.size() == 0) chk("oe_unexpected", 32'd1, 32'd0);
                else chk("oe_window_row_plane_len",
                         (32'(win_row) << 24) | (32'(win_plane) << 20) | oe_len,
                         exp_oe.pop_front());
                oe_len = 0;
            end
            if (ifc.row_address != prev_row) chk("oe_off_at_row_change", 32'(panel_oe_n), 32'd1);
            if (frame_done) begin
                if (exp_frame.size() == 0) chk("frame_done_unexpected", 32'd1, 32'd0);
                else chk("frame_done_prevrow_row_col_plane",
                         (32'(prev_row) << 20) | (32'(ifc.row_address) << 16) |
                         (32'(ifc.column_address) << 8) | 32'(ifc.bitplane),
                         exp_frame.pop_front());
            end
        end else begin
            pulses = 0;
            oe_len = 0;
        end
        prev_pclk  = panel_clk;
        prev_latch = panel_latch;
        prev_oe    = panel_oe_n;
        prev_row   = ifc.row_address;
    end

    // Directed stimulus
    initial begin
        int n;
        int bad;
        int nb;
        int starts;
        int latches;
        int oe_low;
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state",
            {15'd0, ifc.column_address, ifc.row_address, ifc.bitplane, ifc.pixel_load_start,
             panel_clk, panel_latch, panel_oe_n, frame_done},
            {15'd0, 6'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        reset = 1'b0;
        @(negedge clk);
        chk("idle_no_start", 32'(ifc.pixel_load_start), 32'd0);

        // Full frame expectations: 64 shift pulses per latch, 8<<p OE-low cycles.
        for (int r = 0; r < 16; r++) begin
            for (int p = 0; p < 6; p++) begin
                exp_latch.push_back(32'd64);
                exp_oe.push_back((32'(r) << 24) | (32'(p) << 20) | (32'd8 << p));
            end
        end
        exp_frame.push_back(32'd15 << 20);
        stall_req = 1'b1;
        mon_en    = 1'b1;
        enable    = 1'b1;

        @(negedge clk);
        chk("first_start_cycle1", 32'(ifc.pixel_load_start), 32'd1);

        n = 0;
        while (ifc.fetch_busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        while (ifc.fetch_busy === 1'b1 && n < 40) begin
            if (panel_clk !== 1'b0) n = 100;
            @(negedge clk); n++;
        end
        chk("first_busy_fall_no_clk", {30'd0, ifc.fetch_busy, panel_clk}, 32'd0);
        @(negedge clk);
        chk("first_pclk_after_busy", 32'(panel_clk), 32'd1);

        // Stall at column 10
        n = 0;
        while (!(ifc.fetch_busy === 1'b1 && ifc.column_address == 6'd10) && n < 300) begin
            @(negedge clk); n++;
        end
        chk("stall_reached", 32'(ifc.column_address), 32'd10);
        bad = 0;
        nb  = 0;
        while (ifc.fetch_busy === 1'b1 && nb < 60) begin
            if (panel_clk !== 1'b0 || ifc.column_address != 6'd10) bad++;
            nb++;
            @(negedge clk);
        end
        chk("stall_busy_cycles", nb, 32'd50);
        chk("stall_hold_clk_col", bad, 32'd0);
        chk("stall_no_clk_at_fall", 32'(panel_clk), 32'd0);
        @(negedge clk);
        chk("stall_resume_pclk", 32'(panel_clk), 32'd1);

        // After the six planes of row 0, plane wraps to 0
        n = 0;
        while (ifc.row_address != 4'd1 && n < 10000) begin @(negedge clk); n++; end
        chk("row1_reached", 32'(ifc.row_address), 32'd1);
        chk("plane_wrap_row1", 32'(ifc.bitplane), 32'd0);

        // Drop enable mid-frame
        n = 0;
        while (ifc.row_address != 4'd5 && n < 20000) begin @(negedge clk); n++; end
        chk("row5_reached", 32'(ifc.row_address), 32'd5);
        enable = 1'b0;
        n = 0;
        while (frame_done !== 1'b1 && n < 50000) begin @(negedge clk); n++; end
        chk("frame_done_seen", 32'(frame_done), 32'd1);
        starts = 0;
        oe_low = 0;
        repeat (200) begin
            @(negedge clk);
            if (ifc.pixel_load_start) starts++;
            if (!panel_oe_n) oe_low++;
        end
        chk("idle_after_frame_starts", starts, 32'd0);
        chk("idle_after_frame_oe_low", oe_low, 32'd0);
        chk("exp_latch_drained", exp_latch.size(), 32'd0);
        chk("exp_oe_drained", exp_oe.size(), 32'd0);
        chk("exp_frame_drained", exp_frame.size(), 32'd0);

        // Reset in DISPLAY at row 7 plane 3, with a short fetch to save time
        mon_en   = 1'b0;
        busy_len = 1;
        enable   = 1'b1;
        n = 0;
        while (!(ifc.row_address == 4'd7 && ifc.bitplane == 3'd3 && panel_oe_n == 1'b0) && n < 30000) begin
            @(negedge clk); n++;
        end
        chk("display_r7_p3_reached", {28'd0, ifc.row_address}, 32'd7);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_display",
            {20'd0, panel_oe_n, ifc.row_address, ifc.bitplane, ifc.column_address},
            {20'd0, 1'b1, 4'd0, 3'd0, 6'd0});
        enable = 1'b0;
        @(negedge clk);
        reset   = 1'b0;
        latches = 0;
        starts  = 0;
        oe_low  = 0;
        repeat (50) begin
            @(negedge clk);
            if (panel_latch) latches++;
            if (ifc.pixel_load_start) starts++;
            if (!panel_oe_n) oe_low++;
        end
        chk("post_reset_no_latch", latches, 32'd0);
        chk("post_reset_idle_starts_oe", starts + oe_low, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
